// File: rtl/sign_mag_addsub_pipe.sv
// Two-stage pipelined sign-magnitude adder/subtractor with valid/ready on both sides.
// Define SMA_CNT_EN to add the 16-bit done_cnt completed-result counter port.
module sign_mag_addsub_pipe #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   sum,
  output logic         zero
`ifdef SMA_CNT_EN
  ,
  output logic [15:0]  done_cnt
`endif
);

  logic         sa, sb, a_ge;
  logic [W-2:0] ma, mb;
  logic         s1_load, s2_load;

  logic         v1_q, eff_add_q, sign1_q;
  logic [W-2:0] big_q, small_q;
  logic         eff_add_d, sign1_d;
  logic [W-2:0] big_d, small_d;

  logic         v2_q, zero_q, zero_d;
  logic [W:0]   sum_q, sum_d;
  logic [W-1:0] mag_d;

  assign sa   = a[W-1];
  assign sb   = b[W-1] ^ sub;
  assign ma   = a[W-2:0];
  assign mb   = b[W-2:0];
  assign a_ge = (ma >= mb);

  // S2 frees up when empty or being drained; S1 may then shift into it.
  assign s2_load  = !v2_q || out_ready;
  assign s1_load  = !v1_q || s2_load;
  assign in_ready = s1_load;

  always_comb begin
    eff_add_d = (sa == sb);
    big_d     = a_ge ? ma : mb;
    small_d   = a_ge ? mb : ma;
    sign1_d   = (eff_add_d || a_ge) ? sa : sb;
  end

  always_comb begin
    mag_d = '0;
    if (eff_add_q) begin
      mag_d = {1'b0, big_q} + {1'b0, small_q};
    end else begin
      mag_d = {1'b0, big_q - small_q};
    end
    zero_d = (mag_d == '0);
    // Canonical zero: never emit a negative zero.
    sum_d  = {(zero_d ? 1'b0 : sign1_q), mag_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      eff_add_q <= 1'b0;
      sign1_q   <= 1'b0;
      big_q     <= '0;
      small_q   <= '0;
    end else if (s1_load) begin
      v1_q <= in_valid;
      if (in_valid) begin
        eff_add_q <= eff_add_d;
        sign1_q   <= sign1_d;
        big_q     <= big_d;
        small_q   <= small_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q   <= 1'b0;
      sum_q  <= '0;
      zero_q <= 1'b0;
    end else if (s2_load) begin
      v2_q <= v1_q;
      if (v1_q) begin
        sum_q  <= sum_d;
        zero_q <= zero_d;
      end
    end
  end

  assign out_valid = v2_q;
  assign sum       = sum_q;
  assign zero      = zero_q;

`ifdef SMA_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
    end else if (v2_q && out_ready) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign done_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_sign_mag_addsub_pipe.sv
// Self-checking bench for sign_mag_addsub_pipe: directed literals plus a randomized stream
// scored against an integer-arithmetic reference model; done_cnt checked under SMA_CNT_EN.
module tb_sign_mag_addsub_pipe;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W:0]   sum;
  logic         zero;
`ifdef SMA_CNT_EN
  logic [15:0]  done_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int exp_cnt = 0;
  logic [W:0] exp_q[$];
  int         acc_q[$];

  sign_mag_addsub_pipe #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .zero      (zero)
`ifdef SMA_CNT_EN
    ,
    .done_cnt  (done_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input bit ok, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: treat operands as signed integers, add, re-encode as sign-magnitude.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic s);
    int va, vb, r;
    va = int'(x[W-2:0]);
    if (x[W-1]) va = -va;
    vb = int'(y[W-2:0]);
    if (y[W-1] ^ s) vb = -vb;
    r = va + vb;
    if (r < 0) return {1'b1, W'(-r)};
    return {1'b0, W'(r)};
  endfunction

  // Scoreboard: checks handshake, ordering and data every cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
      exp_cnt = 0;
    end else begin
      chk(in_ready == ((exp_q.size() < 2) || out_ready), "in_ready", 32'(in_ready),
          32'((exp_q.size() < 2) || out_ready));
      chk(out_valid == (exp_q.size() > 0 && cyc >= acc_q[0] + 1), "out_valid",
          32'(out_valid), 32'(exp_q.size() > 0 && cyc >= acc_q[0] + 1));
      if (out_valid && exp_q.size() > 0) begin
        chk(sum == exp_q[0], "sum_model", 32'(sum), 32'(exp_q[0]));
        chk(zero == (exp_q[0][W-1:0] == '0), "zero_model", 32'(zero),
            32'(exp_q[0][W-1:0] == '0));
      end
`ifdef SMA_CNT_EN
      chk(done_cnt == 16'(exp_cnt), "done_cnt", 32'(done_cnt), 32'(exp_cnt));
`endif
      if (out_valid && out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        void'(acc_q.pop_front());
        exp_cnt++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, sub));
        acc_q.push_back(cyc + 1);
      end
    end
  end

  task automatic send_one(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic s);
    @(posedge clk);
    #1;
    a = xa;
    b = xb;
    sub = s;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_result(input logic [W:0] exp_sum, input logic exp_zero,
                               input string name);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk(out_valid == 1'b1, {name, "_valid"}, 32'(out_valid), 32'd1);
    chk(sum == exp_sum, {name, "_sum"}, 32'(sum), 32'(exp_sum));
    chk(zero == exp_zero, {name, "_zero"}, 32'(zero), 32'(exp_zero));
  endtask

  initial begin
    bit fire;
    int acc_n;
    int idx;

    #2;
    chk(out_valid == 1'b0, "rst_out_valid", 32'(out_valid), 32'd0);
    chk(sum == '0, "rst_sum", 32'(sum), 32'd0);
    chk(zero == 1'b0, "rst_zero", 32'(zero), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk(in_ready == 1'b1, "rst_in_ready", 32'(in_ready), 32'd1);

    // Directed vectors with hand-computed results.
    send_one(8'h86, 8'h83, 1'b0); expect_result(9'h109, 1'b0, "neg_add");
    send_one(8'h96, 8'h87, 1'b0); expect_result(9'h11D, 1'b0, "neg_add2");
    send_one(8'h03, 8'h85, 1'b0); expect_result(9'h102, 1'b0, "mixed");
    send_one(8'h05, 8'h05, 1'b1); expect_result(9'h000, 1'b1, "sub_zero");
    send_one(8'h80, 8'h00, 1'b0); expect_result(9'h000, 1'b1, "neg_zero");
    send_one(8'h7F, 8'h7F, 1'b0); expect_result(9'h0FE, 1'b0, "max_add");
    send_one(8'hFF, 8'h7F, 1'b1); expect_result(9'h1FE, 1'b0, "max_sub");

    // Back-pressure: two accepted, third stalls until out_ready returns.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b1;
    sub = 1'b0;
    a = 8'd1; b = 8'd1;
    @(posedge clk); #1;
    a = 8'd2; b = 8'd2;
    @(posedge clk); #1;
    a = 8'd3; b = 8'd3;
    @(negedge clk);
    chk(in_ready == 1'b0, "bp_in_ready_low", 32'(in_ready), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk(sum == 9'h002, "bp_hold", 32'(sum), 32'h002);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    #1;
    chk(in_ready == 1'b1, "bp_release_ready", 32'(in_ready), 32'd1);
    idx = 0;
    for (int i = 0; i < 12 && idx < 3; i++) begin
      @(negedge clk);
      fire = in_valid && in_ready;
      if (out_valid && out_ready) begin
        chk(sum == (W + 1)'((idx + 1) * 2), "bp_order", 32'(sum), 32'((idx + 1) * 2));
        idx++;
      end
      @(posedge clk);
      #1;
      if (fire) in_valid = 1'b0;
    end
    chk(idx == 3, "bp_count", 32'(idx), 32'd3);

    // Reset with both stages full.
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1;
    a = 8'h11; b = 8'h22;
    @(posedge clk); #1;
    a = 8'h33; b = 8'h44;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk(out_valid == 1'b1, "mid_full", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk(out_valid == 1'b0, "mid_rst_valid", 32'(out_valid), 32'd0);
    chk(sum == '0, "mid_rst_sum", 32'(sum), 32'd0);
`ifdef SMA_CNT_EN
    chk(done_cnt == 16'd0, "mid_rst_cnt", 32'(done_cnt), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk(in_ready == 1'b1, "post_rst_ready", 32'(in_ready), 32'd1);
    repeat (4) begin
      @(negedge clk);
      chk(out_valid == 1'b0, "no_stale", 32'(out_valid), 32'd0);
    end

    // Random stream with random back-pressure.
    acc_n = 0;
    for (int i = 0; i < 5000 && acc_n < 100; i++) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        a = W'($urandom);
        b = W'($urandom);
        sub = 1'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      fire = in_valid && in_ready;
      if (fire) acc_n++;
      @(posedge clk);
      #1;
      if (fire) in_valid = 1'b0;
    end
    chk(acc_n == 100, "stream_accepted", 32'(acc_n), 32'd100);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    chk(exp_q.size() == 0, "stream_drained", 32'(exp_q.size()), 32'd0);
`ifdef SMA_CNT_EN
    chk(done_cnt == 16'd100, "stream_done_cnt", 32'(done_cnt), 32'd100);
`endif

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sign_mag_addsub_pipe.md
# sign_mag_addsub_pipe

- Parametrised, pipelined sign-magnitude adder/subtractor with valid/ready handshaking on both sides.
- Generalises the combinational 8-bit sign-magnitude adder:
  - configurable operand width;
  - per-transaction add/subtract select;
  - canonical zero;
  - a registered two-stage datapath that sustains one operation per cycle under back-pressure.
- Sits between operand-producing logic and result consumers in the arithmetic datapath.

## Interface
- `W`, default 8: operand width, including sign bit (bit W-1). Magnitude is W-1 bits. Legal range W >= 2.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operands and `sub` are valid this cycle.
- `in_ready` output 1: block accepts a transaction when `in_valid && in_ready`.
- `a` input W: operand A, sign-magnitude.
- `b` input W: operand B, sign-magnitude.
- `sub` input 1: 0 = A+B, 1 = A−B.
- `out_valid` output 1: `sum` and `zero` are valid.
- `out_ready` input 1: consumer takes the result when `out_valid && out_ready`.
- `sum` output W+1: result, sign-magnitude. Bit W is the sign; bits W-1:0 are the magnitude.
- `zero` output 1: result magnitude is 0.
- `done_cnt` output 16: completed-result count. Present only with `SMA_CNT_EN`.

## Operation
- Effective B sign: `sb = b[W-1] ^ sub`. A sign: `sa = a[W-1]`. Magnitudes: `ma = a[W-2:0]`, `mb = b[W-2:0]`.
- **Stage 1** (register S1) captures:
  - `eff_add = (sa == sb)`;
  - `big`/`small` magnitudes: `big = max(ma, mb)`, with `ma` chosen on a tie;
  - result sign: `sa` if `eff_add`; otherwise the sign of the larger-magnitude operand, with A's sign on a tie.
- **Stage 2** (register S2) computes the W-bit magnitude:
  - `eff_add`: `big + small`, zero-extended to W bits. It cannot overflow W bits.
  - otherwise: `big − small`, which is never negative.
- **Canonical zero:** if the stage-2 magnitude is 0, the sign is forced to 0 and `zero` = 1. Inputs of −0 (e.g. 0x80 for W=8) are legal and are treated as 0.
- **Handshake:** each stage holds a valid bit.
  - S2 loads when `!v2 || out_ready`.
  - S1 loads when `!v1 || (S2 loads)`.
  - `in_ready = !v1 || !v2 || out_ready` (combinational).
- Results leave in acceptance order. No transaction is dropped or duplicated.
- While `out_valid && !out_ready`, `sum` and `zero` hold stable.
- `in_valid` is ignored when `in_ready` = 0. The producer holds its data.

## Timing
- **Reset** (asynchronous assert, synchronous release):
  - v1 = v2 = 0, `out_valid` = 0, `sum` = 0, `zero` = 0, `done_cnt` = 0;
  - `in_ready` = 1 in the first cycle after release.
- **Latency:** a transaction accepted at edge N gives `out_valid` = 1 after edge N+1, i.e. two register stages. Results are visible in the cycle after the second edge.
- **Throughput:** 1 transaction/cycle while `out_ready` = 1.
- **Back-pressure:** `out_ready` = 0 with both stages full drops `in_ready` to 0 in the same cycle. When `out_ready` returns to 1, `in_ready` = 1 combinationally in that cycle.
- **Simultaneous pop and push:** a pop at S2 and a push at S1 in the same cycle both complete. Occupancy is unchanged.
- **Reset mid-operation:** in-flight transactions are discarded. No `out_valid` after reset until a new acceptance.

## Configuration
- **`SMA_CNT_EN` defined:**
  - the `done_cnt` port exists;
  - it increments by 1 on every cycle with `out_valid && out_ready`;
  - it wraps from 0xFFFF to 0x0000;
  - it resets to 0.
- **`SMA_CNT_EN` undefined:** the port and counter are absent. All other behaviour is identical.

## Test plan
- W=8, `a`=0x86 (−6), `b`=0x83 (−3), `sub`=0 → after 2 cycles `sum`=0x109 (−9), `zero`=0. Then `a`=0x96, `b`=0x87 → `sum`=0x11D (−29).
- Mixed signs and subtract:
  - `a`=0x03, `b`=0x85, `sub`=0 → `sum`=0x102 (−2);
  - `a`=0x05, `b`=0x05, `sub`=1 → `sum`=0x000, `zero`=1;
  - `a`=0x80, `b`=0x00 → `sum`=0x000, `zero`=1.
- Extremes:
  - `a`=0x7F, `b`=0x7F, `sub`=0 → `sum`=0x0FE;
  - `a`=0xFF, `b`=0x7F, `sub`=1 → `sum`=0x1FE.
- Back-pressure:
  - hold `out_ready`=0 and offer 3 transactions (1+1, 2+2, 3+3) on consecutive cycles → `in_ready` drops to 0 after 2 are accepted;
  - release `out_ready` → outputs 0x002, 0x004, 0x006 in order, each held stable while stalled.
- Streaming: 100 random transactions with random `out_ready` (W=8 and W=12) → every result matches the reference model, in order, with none lost. With `SMA_CNT_EN`, `done_cnt`=100.
- Reset mid-operation: assert `rst_n`=0 with both stages full → `out_valid`=0, `sum`=0, `done_cnt`=0 immediately. After release, `in_ready`=1 and no stale result appears.
